// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: dump FSM state encoding and
// default bus/memory dimensions.
package data_mem_pkg;

  localparam int NB_ADDR_DEF   = 32;
  localparam int NB_DATA_DEF   = 32;
  localparam int RAM_DEPTH_DEF = 32;
  localparam int NB_DEPTH_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_WAIT = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/data_memory_arbiter.sv
// Shares data_memory between the MEM stage (pass-through) and the debug unit,
// which can stream the whole memory out over a valid/ready handshake.
module data_memory_arbiter
  import data_mem_pkg::*;
#(
  parameter int NB_ADDR   = NB_ADDR_DEF,
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int NB_DEPTH  = NB_DEPTH_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cpu_read_enable,
  input  logic                i_cpu_write_enable,
  input  logic [NB_ADDR-1:0]  i_cpu_address,
  input  logic [NB_DATA-1:0]  i_cpu_data,
  output logic [NB_DATA-1:0]  o_cpu_data,
  output logic                o_cpu_stall,
  input  logic                i_dbg_dump_start,
  input  logic                i_dbg_ready,
  output logic [NB_DATA-1:0]  o_dbg_data,
  output logic [NB_DEPTH-1:0] o_dbg_address,
  output logic                o_dbg_valid,
  output logic                o_dbg_done,
  output logic                o_dbg_busy,
  output logic                o_mem_write_enable,
  output logic                o_mem_read_enable,
  output logic [NB_ADDR-1:0]  o_mem_write_address,
  output logic [NB_ADDR-1:0]  o_mem_read_address,
  output logic [NB_DATA-1:0]  o_mem_data,
  input  logic [NB_DATA-1:0]  i_mem_data
);

  state_e              state_q, state_d;
  logic [NB_DEPTH-1:0] counter_q, counter_d;
  logic [NB_DATA-1:0]  dbg_data_q, dbg_data_d;
  logic [NB_DEPTH-1:0] dbg_addr_q, dbg_addr_d;
  logic                dbg_valid_q, dbg_valid_d;

  logic cpu_in_range_s;
  logic last_word_s;

  assign cpu_in_range_s = (i_cpu_address < NB_ADDR'(RAM_DEPTH));
  assign last_word_s    = (counter_q == NB_DEPTH'(RAM_DEPTH - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      dbg_data_q  <= '0;
      dbg_addr_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      dbg_data_q  <= dbg_data_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    counter_d           = counter_q;
    dbg_data_d          = dbg_data_q;
    dbg_addr_d          = dbg_addr_q;
    dbg_valid_d         = dbg_valid_q;
    o_mem_write_enable  = 1'b0;
    o_mem_read_enable   = 1'b0;
    o_mem_write_address = i_cpu_address;
    o_mem_read_address  = i_cpu_address;
    o_mem_data          = i_cpu_data;
    o_cpu_data          = '0;
    o_cpu_stall         = i_cpu_read_enable | i_cpu_write_enable;
    o_dbg_done          = 1'b0;

    case (state_q)
      IDLE: begin
        // Out-of-range stores are dropped, out-of-range loads read as zero.
        o_mem_write_enable = i_cpu_write_enable & cpu_in_range_s;
        o_mem_read_enable  = i_cpu_read_enable;
        o_cpu_data         = (i_cpu_read_enable && cpu_in_range_s) ? i_mem_data : '0;
        o_cpu_stall        = 1'b0;
        if (i_dbg_dump_start) begin
          state_d   = DUMP_READ;
          counter_d = '0;
        end
      end
      DUMP_READ: begin
        o_mem_read_enable  = 1'b1;
        o_mem_read_address = NB_ADDR'(counter_q);
        dbg_data_d         = i_mem_data;
        dbg_addr_d         = counter_q;
        dbg_valid_d        = 1'b1;
        state_d            = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (i_dbg_ready) begin
          dbg_valid_d = 1'b0;
          if (last_word_s) begin
            state_d = DONE;
          end else begin
            counter_d = counter_q + NB_DEPTH'(1);
            state_d   = DUMP_READ;
          end
        end
      end
      DONE: begin
        o_dbg_done = 1'b1;
        counter_d  = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_dbg_data    = dbg_data_q;
  assign o_dbg_address = dbg_addr_q;
  assign o_dbg_valid   = dbg_valid_q;
  assign o_dbg_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: behavioural 32-word memory, table-driven
// pass-through vectors and a scoreboard for dump beats.
module tb_data_memory_arbiter;

  localparam int RAM_DEPTH = 32;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cpu_read_enable = 1'b0;
  logic        i_cpu_write_enable = 1'b0;
  logic [31:0] i_cpu_address = 32'd0;
  logic [31:0] i_cpu_data = 32'd0;
  logic [31:0] o_cpu_data;
  logic        o_cpu_stall;
  logic        i_dbg_dump_start = 1'b0;
  logic        i_dbg_ready = 1'b1;
  logic [31:0] o_dbg_data;
  logic [4:0]  o_dbg_address;
  logic        o_dbg_valid;
  logic        o_dbg_done;
  logic        o_dbg_busy;
  logic        o_mem_write_enable;
  logic        o_mem_read_enable;
  logic [31:0] o_mem_write_address;
  logic [31:0] o_mem_read_address;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;

  data_memory_arbiter dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cpu_read_enable(i_cpu_read_enable), .i_cpu_write_enable(i_cpu_write_enable),
    .i_cpu_address(i_cpu_address), .i_cpu_data(i_cpu_data),
    .o_cpu_data(o_cpu_data), .o_cpu_stall(o_cpu_stall),
    .i_dbg_dump_start(i_dbg_dump_start), .i_dbg_ready(i_dbg_ready),
    .o_dbg_data(o_dbg_data), .o_dbg_address(o_dbg_address),
    .o_dbg_valid(o_dbg_valid), .o_dbg_done(o_dbg_done), .o_dbg_busy(o_dbg_busy),
    .o_mem_write_enable(o_mem_write_enable), .o_mem_read_enable(o_mem_read_enable),
    .o_mem_write_address(o_mem_write_address), .o_mem_read_address(o_mem_read_address),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  // Memory model: low address bits only, so an ungated out-of-range access aliases visibly.
  logic [31:0] mem [RAM_DEPTH];
  always @(posedge i_clock) begin
    if (o_mem_write_enable) mem[o_mem_write_address[4:0]] <= o_mem_data;
  end
  assign i_mem_data = mem[o_mem_read_address[4:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_we;
    logic        exp_re;
    logic [31:0] exp_cdata;
  } vec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];

  task automatic cpu_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data);
    @(posedge i_clock); #1;
    i_cpu_read_enable  = rd;
    i_cpu_write_enable = wr;
    i_cpu_address      = addr;
    i_cpu_data         = data;
    @(negedge i_clock);
  endtask

  task automatic run_dump(input int hold_word, input int rst_word, input bit poke,
                          output int done_cyc, output int beats, output int dones);
    int    c0;
    int    held;
    bit    fin;
    bit    hold;
    beat_t e;
    beat_t got;
    done_cyc = -1; beats = 0; dones = 0; held = 0; fin = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      e.addr = 5'(i);
      e.data = 32'(i * 3);
      exp_q.push_back(e);
    end
    @(posedge i_clock); #1;
    i_cpu_read_enable = 1'b0; i_cpu_write_enable = 1'b0;
    i_dbg_dump_start = 1'b1; i_dbg_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(posedge i_clock); #1;
      i_dbg_dump_start   = (cyc - c0 == 20);
      i_cpu_write_enable = poke && (cyc - c0 >= 1) && (cyc - c0 <= 3);
      i_cpu_address      = 32'd2;
      i_cpu_data         = 32'h0000_0BAD;
      if (rst_word >= 0 && o_dbg_valid && o_dbg_address == 5'(rst_word)) begin
        i_reset = 1'b0; i_dbg_ready = 1'b0;
        @(posedge i_clock); #1;
        chk("rst_mid_valid", {31'd0, o_dbg_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_dbg_busy}, 32'd0);
        chk("rst_mid_done", {31'd0, o_dbg_done}, 32'd0);
        i_reset = 1'b1; i_dbg_ready = 1'b1;
        exp_q.delete();
        for (int j = 0; j < 6; j++) begin
          @(negedge i_clock);
          if (o_dbg_done) dones++;
          chk("rst_after_valid", {31'd0, o_dbg_valid}, 32'd0);
        end
        fin = 1'b1;
      end else begin
        hold = (hold_word >= 0) && o_dbg_valid && (o_dbg_address == 5'(hold_word)) && (held < 4);
        i_dbg_ready = !hold;
        if (hold) held++;
        @(negedge i_clock);
        if (hold) begin
          chk("hold_valid", {31'd0, o_dbg_valid}, 32'd1);
          chk("hold_addr", {27'd0, o_dbg_address}, 32'(hold_word));
          chk("hold_data", o_dbg_data, 32'(hold_word * 3));
        end
        if (i_cpu_write_enable) begin
          chk("dump_cpu_stall", {31'd0, o_cpu_stall}, 32'd1);
          chk("dump_mem_we", {31'd0, o_mem_write_enable}, 32'd0);
          chk("dump_cpu_data", o_cpu_data, 32'd0);
        end
        if (o_dbg_valid && i_dbg_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
          end else begin
            got = exp_q.pop_front();
            chk("beat_addr", {27'd0, o_dbg_address}, {27'd0, got.addr});
            chk("beat_data", o_dbg_data, got.data);
          end
        end
        if (o_dbg_done) begin
          dones++;
          done_cyc = cyc - c0;
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk("dump_timeout", 32'd0, 32'd1);
    i_cpu_write_enable = 1'b0;
    i_dbg_dump_start   = 1'b0;
    if (rst_word < 0) begin
      @(negedge i_clock);
      chk("busy_after_done", {31'd0, o_dbg_busy}, 32'd0);
      chk("done_one_cycle", {31'd0, o_dbg_done}, 32'd0);
    end
  endtask

  vec_t vecs[12];
  int   dc, nb, nd;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd5,  32'hDEADBEEF, 1'b1, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd5,  32'd0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'd40, 32'h00001234, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'd40, 32'd0,        1'b0, 1'b1, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'd8,  32'd0,        1'b0, 1'b1, 32'd24};
    vecs[5]  = '{1'b0, 1'b1, 32'd31, 32'h00005A5A, 1'b1, 1'b0, 32'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'd31, 32'd0,        1'b0, 1'b1, 32'h00005A5A};
    vecs[7]  = '{1'b1, 1'b0, 32'd32, 32'd0,        1'b0, 1'b1, 32'd0};
    vecs[8]  = '{1'b0, 1'b0, 32'd3,  32'd0,        1'b0, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'd5,  32'd15,       1'b1, 1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b1, 32'd31, 32'd93,       1'b1, 1'b0, 32'd0};
    vecs[11] = '{1'b1, 1'b0, 32'd31, 32'd0,        1'b0, 1'b1, 32'd93};

    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    chk("reset_valid", {31'd0, o_dbg_valid}, 32'd0);
    chk("reset_done", {31'd0, o_dbg_done}, 32'd0);
    chk("reset_data", o_dbg_data, 32'd0);
    chk("reset_addr", {27'd0, o_dbg_address}, 32'd0);
    chk("reset_busy", {31'd0, o_dbg_busy}, 32'd0);
    i_reset = 1'b1;

    for (int i = 0; i < RAM_DEPTH; i++) cpu_cycle(1'b0, 1'b1, 32'(i), 32'(i * 3));

    foreach (vecs[i]) begin
      cpu_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_we", i), {31'd0, o_mem_write_enable}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_re", i), {31'd0, o_mem_read_enable}, {31'd0, vecs[i].exp_re});
      chk($sformatf("vec%0d_cdata", i), o_cpu_data, vecs[i].exp_cdata);
      chk($sformatf("vec%0d_stall", i), {31'd0, o_cpu_stall}, 32'd0);
    end
    cpu_cycle(1'b0, 1'b0, 32'd0, 32'd0);

    // Full dump with a CPU store to addr 2 attempted right after start.
    run_dump(-1, -1, 1'b1, dc, nb, nd);
    chk("full_done_cycle", 32'(dc), 32'(2 * RAM_DEPTH + 1));
    chk("full_beats", 32'(nb), 32'(RAM_DEPTH));
    chk("full_dones", 32'(nd), 32'd1);
    cpu_cycle(1'b1, 1'b0, 32'd2, 32'd0);
    chk("mem2_untouched", o_cpu_data, 32'd6);

    // Backpressure on word 7 for 4 cycles.
    run_dump(7, -1, 1'b0, dc, nb, nd);
    chk("bp_done_cycle", 32'(dc), 32'(2 * RAM_DEPTH + 1 + 4));
    chk("bp_beats", 32'(nb), 32'(RAM_DEPTH));
    chk("bp_dones", 32'(nd), 32'd1);

    // Reset while word 10 is presented.
    run_dump(-1, 10, 1'b0, dc, nb, nd);
    chk("rst_beats", 32'(nb), 32'd10);
    chk("rst_dones", 32'(nd), 32'd0);

    // Clean dump after the aborted one; includes an ignored mid-dump start.
    run_dump(-1, -1, 1'b0, dc, nb, nd);
    chk("redump_beats", 32'(nb), 32'(RAM_DEPTH));
    chk("redump_dones", 32'(nd), 32'd1);
    chk("redump_queue_empty", 32'(exp_q.size()), 32'd0);

    cpu_cycle(1'b0, 1'b1, 32'd2, 32'h0000_0BAD);
    chk("post_dump_we", {31'd0, o_mem_write_enable}, 32'd1);
    cpu_cycle(1'b1, 1'b0, 32'd2, 32'd0);
    chk("post_dump_read", o_cpu_data, 32'h0000_0BAD);
    chk("post_dump_stall", {31'd0, o_cpu_stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
